// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for the half-precision MAC: result = bias + sum a[k]*b[k].
// Fetches operand pairs from two synchronous RAMs and feeds the MAC result back as c.
module mac_dot_seq #(
  parameter int ADDR_W  = 8,
  parameter int MAC_LAT = 3
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [31:0]       bias,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [15:0]       rdata_a,
  input  logic [15:0]       rdata_b,
  output logic [15:0]       mac_a,
  output logic [15:0]       mac_b,
  output logic [31:0]       mac_c,
  input  logic [31:0]       mac_q,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result
);

  localparam int W_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [W_W-1:0] W_LAST = W_W'(MAC_LAT);
  localparam logic [W_W-1:0] W_PRE  = W_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   k;
  logic [ADDR_W-1:0]   len_r;
  logic [ADDR_W-1:0]   base_a_r;
  logic [ADDR_W-1:0]   base_b_r;
  logic signed [31:0]  acc;
  logic [W_W-1:0]      w;
  logic [ADDR_W:0]     k_ext_inc;
  logic [ADDR_W-1:0]   k_inc;
  logic                more;

  // Extra bit on the compare so k+1 never wraps before it is checked against len.
  assign k_ext_inc = {1'b0, k} + {{ADDR_W{1'b0}}, 1'b1};
  assign k_inc     = k_ext_inc[ADDR_W-1:0];
  assign more      = k_ext_inc < {1'b0, len_r};

  // Operand data arrives from the RAMs in the issue cycle itself, so the MAC feed is decoded.
  assign mac_a = (state == ISSUE) ? rdata_a : '0;
  assign mac_b = (state == ISSUE) ? rdata_b : '0;
  assign mac_c = (state == ISSUE) ? acc     : '0;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      k        <= '0;
      len_r    <= '0;
      base_a_r <= '0;
      base_b_r <= '0;
      acc      <= '0;
      w        <= '0;
      rd_en    <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          len_r    <= len;
          base_a_r <= base_a;
          base_b_r <= base_b;
          acc      <= bias;
          k        <= '0;
          busy     <= 1'b1;
          if (len != '0) begin
            state  <= FETCH;
            rd_en  <= 1'b1;
            addr_a <= base_a;
            addr_b <= base_b;
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            result <= bias;
          end
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          FETCH: state <= ISSUE;
          ISSUE: begin
            state <= WAIT;
            w     <= W_W'(1);
            // With a single-cycle MAC the look-ahead read lands in the first wait cycle.
            if (MAC_LAT == 1 && more) begin
              rd_en  <= 1'b1;
              addr_a <= base_a_r + k_inc;
              addr_b <= base_b_r + k_inc;
            end
          end
          WAIT: begin
            if (w == W_LAST) begin
              acc <= mac_q;
              k   <= k_inc;
              if (more) begin
                state <= ISSUE;
              end else begin
                state  <= DONE;
                done   <= 1'b1;
                result <= mac_q;
              end
            end else begin
              w <= w + W_W'(1);
              if (w == W_PRE && more) begin
                rd_en  <= 1'b1;
                addr_a <= base_a_r + k_inc;
                addr_b <= base_b_r + k_inc;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
